// File: rtl/la_iorxdiff_chan.sv
// Single differential receive channel: pad synchronizer, decode, glitch filter
// and fail-safe fault detection.
module la_iorxdiff_chan #(
   parameter int unsigned STAGES   = 2,
   parameter int unsigned FILTER   = 4,
   parameter int unsigned FAULTCNT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic padp,
   input  logic padn,
   input  logic ie,
   output logic zp,
   output logic zn,
   output logic fault
);

   localparam int unsigned CW = (FILTER > 1) ? $clog2(FILTER + 1) : 1;
   localparam int unsigned FW = (FAULTCNT > 1) ? $clog2(FAULTCNT + 1) : 1;
   localparam logic [CW-1:0] FiltLast = CW'(FILTER - 1);
   localparam logic [FW-1:0] FaultMax = FW'(FAULTCNT);

   logic [STAGES-1:0] syncp_q;
   logic [STAGES-1:0] syncn_q;
   logic              sp;
   logic              sn;
   logic              valid;
   logic              d;
   logic [CW-1:0]     cnt_q;
   logic [CW-1:0]     cnt_d;
   logic [FW-1:0]     fcnt_q;
   logic [FW-1:0]     fcnt_d;
   logic              zp_d;
   logic              fault_d;

   assign sp    = syncp_q[STAGES-1];
   assign sn    = syncn_q[STAGES-1];
   assign valid = sp ^ sn;
   assign d     = sp & ~sn;

   always_comb begin
      cnt_d   = cnt_q;
      fcnt_d  = fcnt_q;
      zp_d    = zp;
      fault_d = fault;
      if (!ie) begin
         cnt_d   = '0;
         fcnt_d  = '0;
         zp_d    = 1'b0;
         fault_d = 1'b0;
      end else if (valid) begin
         fcnt_d  = '0;
         fault_d = 1'b0;
         if (d != zp) begin
            if (cnt_q == FiltLast) begin
               zp_d  = d;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            cnt_d = '0;
         end
      end else begin
         // Both legs equal: hold data, count towards the fail-safe fault.
         cnt_d = '0;
         if (fcnt_q != FaultMax) begin
            fcnt_d = fcnt_q + 1'b1;
         end
         fault_d = (fcnt_d == FaultMax);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         syncp_q <= '0;
         syncn_q <= '0;
         cnt_q   <= '0;
         fcnt_q  <= '0;
         zp      <= 1'b0;
         zn      <= 1'b1;
         fault   <= 1'b0;
      end else begin
         syncp_q <= {syncp_q[STAGES-2:0], padp};
         syncn_q <= {syncn_q[STAGES-2:0], padn};
         cnt_q   <= cnt_d;
         fcnt_q  <= fcnt_d;
         zp      <= zp_d;
         zn      <= ~zp_d;
         fault   <= fault_d;
      end
   end

endmodule

// File: rtl/la_iorxdiff_filt.sv
// Multi-channel clocked differential receiver IO cell with per-channel glitch
// filter and fail-safe fault flag.
module la_iorxdiff_filt #(
   parameter              PROP     = "DEFAULT",
   parameter              SIDE     = "NO",
   parameter int unsigned N        = 1,
   parameter int unsigned STAGES   = 2,
   parameter int unsigned FILTER   = 4,
   parameter int unsigned FAULTCNT = 8,
   parameter int unsigned CFGW     = 16,
   parameter int unsigned RINGW    = 8
) (
   input  logic             clk,
   input  logic             rst,
   inout  wire  [N-1:0]     padp,
   inout  wire  [N-1:0]     padn,
   inout  wire              vdd,
   inout  wire              vss,
   inout  wire              vddio,
   inout  wire              vssio,
   input  logic [N-1:0]     ie,
   output logic [N-1:0]     zp,
   output logic [N-1:0]     zn,
   output logic [N-1:0]     fault,
   inout  wire  [RINGW-1:0] ioring,
   input  logic [CFGW-1:0]  cfg
);

   // Cell property and ring side only matter to physical implementation.
   localparam bit unused_cell_params = (PROP != 0) || (SIDE != 0);

   logic unused_pins;
   assign unused_pins = ^{vdd, vss, vddio, vssio, ioring, cfg};

   for (genvar i = 0; i < N; i++) begin : g_chan
      la_iorxdiff_chan #(
         .STAGES   (STAGES),
         .FILTER   (FILTER),
         .FAULTCNT (FAULTCNT)
      ) u_chan (
         .clk   (clk),
         .rst   (rst),
         .padp  (padp[i]),
         .padn  (padn[i]),
         .ie    (ie[i]),
         .zp    (zp[i]),
         .zn    (zn[i]),
         .fault (fault[i])
      );
   end

endmodule

// File: tb/tb_la_iorxdiff_filt.sv
// Self-checking bench: a default single-channel instance and a 4-channel
// FILTER=1 STAGES=3 instance, both compared against a sample-window model.
module tb_la_iorxdiff_filt;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pa_p = 1'b0, pa_n = 1'b1, ie_a = 1'b1;
   logic [3:0] pb_p = 4'h0, pb_n = 4'hf, ie_b = 4'hf;
   logic [15:0] cfg_a = 16'h0, cfg_b = 16'h0;
   logic [0:0] zp_a, zn_a, fault_a;
   logic [3:0] zp_b, zn_b, fault_b;
   wire  [0:0] w_pa_p, w_pa_n;
   wire  [3:0] w_pb_p, w_pb_n;
   wire        vdd, vss, vddio, vssio;
   wire  [7:0] ring_a, ring_b;

   assign w_pa_p = pa_p;
   assign w_pa_n = pa_n;
   assign w_pb_p = pb_p;
   assign w_pb_n = pb_n;

   int n_cmp = 0;
   int n_bad = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   la_iorxdiff_filt u_dut_a (
      .clk (clk), .rst (rst), .padp (w_pa_p), .padn (w_pa_n),
      .vdd (vdd), .vss (vss), .vddio (vddio), .vssio (vssio),
      .ie (ie_a), .zp (zp_a), .zn (zn_a), .fault (fault_a),
      .ioring (ring_a), .cfg (cfg_a)
   );

   la_iorxdiff_filt #(.N(4), .STAGES(3), .FILTER(1), .FAULTCNT(8)) u_dut_b (
      .clk (clk), .rst (rst), .padp (w_pb_p), .padn (w_pb_n),
      .vdd (vdd), .vss (vss), .vddio (vddio), .vssio (vssio),
      .ie (ie_b), .zp (zp_b), .zn (zn_b), .fault (fault_b),
      .ioring (ring_b), .cfg (cfg_b)
   );

   // Model: channel 0 = DUT a, channels 1..4 = DUT b.
   int        stg [5] = '{2, 3, 3, 3, 3};
   int        flt [5] = '{4, 1, 1, 1, 1};
   int        fc  [5] = '{8, 8, 8, 8, 8};
   bit [1:0]  pipe [5][4];
   bit [1:0]  hist [5][16];
   int        hlen [5];
   bit        mzp [5];
   bit        mfault [5];

   // zp follows d once the last FILTER samples since restart are all valid and
   // disagree with zp; fault is set while the last FAULTCNT samples are invalid.
   task automatic model_chan(input int c, input bit p, input bit n, input bit en);
      bit [1:0] s;
      bit ok;
      s = pipe[c][stg[c]-1];
      for (int i = 3; i > 0; i--) pipe[c][i] = pipe[c][i-1];
      pipe[c][0] = {p, n};
      if (rst) begin
         for (int i = 0; i < 4; i++) pipe[c][i] = 2'b00;
      end
      if (rst || !en) begin
         hlen[c] = 0;
         mzp[c] = 1'b0;
         mfault[c] = 1'b0;
         return;
      end
      for (int i = 15; i > 0; i--) hist[c][i] = hist[c][i-1];
      hist[c][0] = s;
      if (hlen[c] < 16) hlen[c]++;
      ok = (hlen[c] >= fc[c]);
      for (int i = 0; i < fc[c]; i++) if (hist[c][i][1] ^ hist[c][i][0]) ok = 1'b0;
      mfault[c] = ok;
      ok = (hlen[c] >= flt[c]);
      for (int i = 0; i < flt[c]; i++) begin
         if (!(hist[c][i][1] ^ hist[c][i][0])) ok = 1'b0;
         else if ((hist[c][i][1] & ~hist[c][i][0]) == mzp[c]) ok = 1'b0;
      end
      if (ok) mzp[c] = hist[c][0][1] & ~hist[c][0][0];
   endtask

   task automatic tick();
      @(posedge clk);
      model_chan(0, pa_p, pa_n, ie_a);
      for (int i = 0; i < 4; i++) model_chan(i + 1, pb_p[i], pb_n[i], ie_b[i]);
      #1;
      started = 1'b1;
   endtask

   // zn is always the complement of zp; fault never coexists with a valid sample.
   always @(negedge clk) begin
      if (started) begin
         n_cmp++;
         if (zn_a !== ~zp_a) begin
            n_bad++;
            $display("FAIL zn_a_compl: zn=%b zp=%b", zn_a, zp_a);
         end
         n_cmp++;
         if (zn_b !== ~zp_b) begin
            n_bad++;
            $display("FAIL zn_b_compl: zn=%b zp=%b", zn_b, zp_b);
         end
         n_cmp++;
         if (fault_a === 1'b1 && hlen[0] > 0 && (hist[0][0][1] ^ hist[0][0][0])) begin
            n_bad++;
            $display("FAIL fault_while_valid: fault=%b sample=%b", fault_a, hist[0][0]);
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; pa_p = 1'b1; pa_n = 1'b0; ie_a = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++;
         if (zp_a !== 1'b0 || zn_a !== 1'b1 || fault_a !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_vals: zp=%b zn=%b fault=%b want 0 1 0", zp_a, zn_a, fault_a);
         end
         n_cmp++;
         if (zp_b !== 4'h0 || fault_b !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_vals_b: zp=%h fault=%h want 0 0", zp_b, fault_b);
         end
      end
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         n_cmp++;
         if (zp_a !== 1'(k >= 6)) begin
            n_bad++;
            $display("FAIL reset_latency edge %0d: zp=%b want %b", k, zp_a, k >= 6);
         end
      end
   endtask

   task automatic test_glitch();
      int ones;
      int first;
      pa_p = 1'b0; pa_n = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      n_cmp++;
      if (zp_a !== 1'b0) begin
         n_bad++;
         $display("FAIL glitch_settle: zp=%b want 0", zp_a);
      end
      for (int len = 3; len <= 4; len++) begin
         ones = 0;
         first = -1;
         for (int k = 1; k <= 16; k++) begin
            pa_p = (k <= len); pa_n = !(k <= len);
            tick();
            if (zp_a === 1'b1) begin
               ones++;
               if (first < 0) first = k;
            end
            n_cmp++;
            if (zp_a !== mzp[0]) begin
               n_bad++;
               $display("FAIL glitch_model len %0d edge %0d: zp=%b want %b", len, k, zp_a, mzp[0]);
            end
         end
         n_cmp++;
         if (ones != ((len == 4) ? 4 : 0)) begin
            n_bad++;
            $display("FAIL glitch_width len %0d: high %0d cycles want %0d", len, ones,
                     (len == 4) ? 4 : 0);
         end
         if (len == 4) begin
            n_cmp++;
            if (first != 6) begin
               n_bad++;
               $display("FAIL glitch_delay: first high edge %0d want 6", first);
            end
         end
      end
   endtask

   task automatic test_failsafe();
      pa_p = 1'b1; pa_n = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      n_cmp++;
      if (zp_a !== 1'b1) begin
         n_bad++;
         $display("FAIL failsafe_pre: zp=%b want 1", zp_a);
      end
      for (int k = 1; k <= 14; k++) begin
         pa_p = 1'b1; pa_n = (k <= 10);
         tick();
         n_cmp++;
         if (fault_a !== 1'(k >= 10 && k <= 12) || zp_a !== 1'b1) begin
            n_bad++;
            $display("FAIL failsafe edge %0d: fault=%b zp=%b want %b 1", k, fault_a, zp_a,
                     k >= 10 && k <= 12);
         end
         n_cmp++;
         if (fault_a !== mfault[0]) begin
            n_bad++;
            $display("FAIL failsafe_model edge %0d: fault=%b want %b", k, fault_a, mfault[0]);
         end
      end
   endtask

   task automatic test_ie();
      pa_p = 1'b1; pa_n = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      ie_a = 1'b0;
      tick();
      n_cmp++;
      if (zp_a !== 1'b0 || zn_a !== 1'b1 || fault_a !== 1'b0) begin
         n_bad++;
         $display("FAIL ie_drop: zp=%b zn=%b fault=%b want 0 1 0", zp_a, zn_a, fault_a);
      end
      tick(); tick();
      ie_a = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         n_cmp++;
         if (zp_a !== 1'(k >= 4)) begin
            n_bad++;
            $display("FAIL ie_restart edge %0d: zp=%b want %b", k, zp_a, k >= 4);
         end
      end
   endtask

   task automatic test_multi();
      logic [3:0] pat [40];
      logic [3:0] base;
      ie_b = 4'hf;
      for (int j = 0; j < 40; j++) begin
         pat[j] = 4'($urandom);
         pb_p = pat[j]; pb_n = ~pat[j];
         tick();
         if (j >= 3) begin
            n_cmp++;
            if (zp_b !== pat[j-3]) begin
               n_bad++;
               $display("FAIL multi_delay step %0d: zp=%h want %h", j, zp_b, pat[j-3]);
            end
         end
      end
      base = 4'($urandom);
      pb_p = base; pb_n = ~base;
      for (int k = 0; k < 5; k++) tick();
      for (int k = 0; k < 12; k++) begin
         pb_p[1] = ~pb_p[1]; pb_n[1] = ~pb_p[1];
         tick();
         n_cmp++;
         if ({zp_b[3:2], zp_b[0]} !== {base[3:2], base[0]} || zp_b[1] !== mzp[2]) begin
            n_bad++;
            $display("FAIL multi_isolate step %0d: zp=%h want %h/%b", k, zp_b, base, mzp[2]);
         end
      end
   endtask

   task automatic test_random();
      bit [1:0] va;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(3, 0) == 0) begin
            va = 2'($urandom);
            pa_p = va[1]; pa_n = va[0];
         end
         ie_a = ($urandom_range(19, 0) != 0);
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(2, 0) == 0) begin
               va = 2'($urandom);
               pb_p[i] = va[1]; pb_n[i] = va[0];
            end
            ie_b[i] = ($urandom_range(24, 0) != 0);
         end
         rst = ($urandom_range(99, 0) == 0);
         cfg_a = 16'($urandom); cfg_b = 16'($urandom);
         tick();
         n_cmp++;
         if (zp_a !== mzp[0] || fault_a !== mfault[0]) begin
            n_bad++;
            $display("FAIL random_a step %0d: zp=%b fault=%b want %b %b", k, zp_a, fault_a,
                     mzp[0], mfault[0]);
         end
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (zp_b[i] !== mzp[i+1] || fault_b[i] !== mfault[i+1]) begin
               n_bad++;
               $display("FAIL random_b ch %0d step %0d: zp=%b fault=%b want %b %b", i, k,
                        zp_b[i], fault_b[i], mzp[i+1], mfault[i+1]);
            end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      for (int c = 0; c < 5; c++) begin
         hlen[c] = 0; mzp[c] = 1'b0; mfault[c] = 1'b0;
         for (int i = 0; i < 4; i++) pipe[c][i] = 2'b00;
         for (int i = 0; i < 16; i++) hist[c][i] = 2'b00;
      end
      test_reset();
      test_glitch();
      test_failsafe();
      test_ie();
      test_multi();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
